// File: rtl/spi_burst_memory_pkg.sv
// Shared definitions for the SPI burst memory: FSM state encoding and
// the polarity of the read/write bit that follows the address field.
package spi_burst_memory_pkg;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_CMD  = 4'd1,
      S_RD   = 4'd2,
      S_WR   = 4'd3
   } state_t;

   // Value of the R/W bit that selects a read burst.
   localparam logic RW_READ = 1'b1;

endpackage

// File: rtl/spi_input_conditioner.sv
// Brings one raw, asynchronous pad input into the clk domain through a
// two-flop synchroniser and produces single-cycle rise/fall pulses.
// RST_VAL sets the level the chain assumes while in reset, so that the
// first real sample after reset does not produce a spurious edge.
module spi_input_conditioner #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic sync1;
   logic sync2;
   logic prev;

   // Synchroniser stages plus one delayed copy for edge detection.
   // NOTE: non-blocking assignments let every stage capture the previous
   // stage's old value, which is what makes this a shift chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= RST_VAL;
         sync2 <= RST_VAL;
         prev  <= RST_VAL;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign level = sync2;
   assign rise  = sync2 & ~prev;
   assign fall  = ~sync2 & prev;

endmodule

// File: rtl/spi_burst_memory.sv
// SPI-slave register memory with burst access. A frame is ADDR_W address
// bits, one R/W bit, then any number of DATA_W-bit words; the address
// auto-increments (mod DEPTH) after every complete word. SCLK is
// oversampled by clk, so clk must run at least 8x faster than SCLK.
module spi_burst_memory #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8,
   parameter int CPOL   = 0,
   parameter int CPHA   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk_pin,
   input  logic              cs_pin,
   input  logic              mosi_pin,
   input  logic              fault_en,
   output logic              miso,
   output logic              miso_oe,
   output logic [DATA_W-1:0] last_word,
   output logic [3:0]        state
);

   import spi_burst_memory_pkg::*;

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CNT_W = $clog2(MAX_W + 1);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;

   // SCLK idles at CPOL, so the chain starts there and reset produces no edge.
   spi_input_conditioner #(.RST_VAL(CPOL != 0)) u_sclk (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (sclk_pin),
      .level (sclk_lvl),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   // CS starts "asserted": a frame already running at reset release then
   // yields no fall edge and is ignored until CS has been seen high.
   spi_input_conditioner #(.RST_VAL(1'b0)) u_cs (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (cs_pin),
      .level (cs_lvl),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   spi_input_conditioner #(.RST_VAL(1'b0)) u_mosi (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (mosi_pin),
      .level (mosi_lvl),
      .rise  (mosi_rise),
      .fall  (mosi_fall)
   );

   // Levels/edges this block has no use for.
   logic unused_cond;
   assign unused_cond = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

   logic lead_edge, trail_edge, sample_edge, shift_edge;

   // Map raw SCLK edges onto leading/trailing, then onto sample/shift by CPHA.
   // NOTE: every signal is assigned on every path through this block, so no
   // latch can be inferred.
   always_comb begin
      lead_edge   = (CPOL == 0) ? sclk_rise : sclk_fall;
      trail_edge  = (CPOL == 0) ? sclk_fall : sclk_rise;
      sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
      shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
   end

   state_t              state_q;
   logic [CNT_W-1:0]    bit_cnt;
   logic [ADDR_W-1:0]   addr;
   logic [DATA_W-1:0]   rd_sr;
   logic [DATA_W-1:0]   rd_word;
   logic [DATA_W-1:0]   wr_sr;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic [ADDR_W-1:0]   addr_next;
   logic [DATA_W-1:0]   wr_word;
   logic                word_done;
   logic                wr_fire;

   assign addr_next = addr + ADDR_W'(1);
   assign wr_word   = {wr_sr[DATA_W-2:0], mosi_lvl};
   assign word_done = (bit_cnt == CNT_W'(DATA_W - 1));
   assign wr_fire   = (state_q == S_WR) && sample_edge && !cs_rise && word_done && !fault_en;
   assign state     = state_q;

   // Frame FSM with counters, shift registers and registered pad outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         bit_cnt   <= '0;
         addr      <= '0;
         rd_sr     <= '0;
         rd_word   <= '0;
         wr_sr     <= '0;
         miso      <= 1'b0;
         miso_oe   <= 1'b0;
         last_word <= '0;
      end else if (cs_rise) begin
         // Deselect wins over any coincident SCLK edge; a partial word is dropped.
         state_q <= S_IDLE;
         bit_cnt <= '0;
         miso    <= 1'b0;
         miso_oe <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               miso <= 1'b0;
               if (cs_fall) begin
                  state_q <= S_CMD;
                  bit_cnt <= '0;
                  addr    <= '0;
                  miso_oe <= 1'b1;
               end
            end
            S_CMD: begin
               if (sample_edge) begin
                  if (bit_cnt == CNT_W'(ADDR_W)) begin
                     bit_cnt <= '0;
                     if (mosi_lvl == RW_READ) begin
                        state_q <= S_RD;
                        rd_sr   <= mem[addr];
                        rd_word <= mem[addr];
                     end else begin
                        state_q <= S_WR;
                     end
                  end else begin
                     addr    <= {addr[ADDR_W-2:0], mosi_lvl};
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end
            S_RD: begin
               if (shift_edge) begin
                  miso <= rd_sr[DATA_W-1];
                  if (word_done) begin
                     last_word <= rd_word;
                     addr      <= addr_next;
                     rd_sr     <= mem[addr_next];
                     rd_word   <= mem[addr_next];
                     bit_cnt   <= '0;
                  end else begin
                     rd_sr   <= rd_sr << 1;
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end
            S_WR: begin
               if (sample_edge) begin
                  wr_sr <= wr_word;
                  if (word_done) begin
                     last_word <= wr_word;
                     addr      <= addr_next;
                     bit_cnt   <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Single write port into the register array.
   // NOTE: the array has no reset; clearing it would turn it into DEPTH*DATA_W
   // resettable flops instead of a plain memory.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[addr] <= wr_word;
      end
   end

endmodule

// File: tb/tb_spi_burst_memory.sv
// Self-checking bench: a mode-0 default build and a mode-3 16/4 build are
// driven by a bit-level SPI master and compared with an array model.
module tb_spi_burst_memory;

   localparam int H = 8;  // SCLK half-period in clk cycles

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        sclk0, cs0, mosi0, fault0, miso0, oe0;
   logic [7:0]  lw0;
   logic [3:0]  st0;
   logic        sclk1, cs1, mosi1, fault1, miso1, oe1;
   logic [15:0] lw1;
   logic [3:0]  st1;

   spi_burst_memory #(.ADDR_W(7), .DATA_W(8), .CPOL(0), .CPHA(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .sclk_pin(sclk0), .cs_pin(cs0), .mosi_pin(mosi0),
      .fault_en(fault0), .miso(miso0), .miso_oe(oe0), .last_word(lw0), .state(st0)
   );

   spi_burst_memory #(.ADDR_W(4), .DATA_W(16), .CPOL(1), .CPHA(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .sclk_pin(sclk1), .cs_pin(cs1), .mosi_pin(mosi1),
      .fault_en(fault1), .miso(miso1), .miso_oe(oe1), .last_word(lw1), .state(st1)
   );

   int checks = 0;
   int errors = 0;

   logic [15:0] tx [$];
   logic [15:0] rx [$];
   logic [3:0]  mid_state, end_state;
   logic        mid_oe, end_oe;

   // Reference model: word arrays and the expected last_word per build.
   logic [7:0]  m0 [128];
   logic [15:0] m1 [16];
   logic [15:0] exp_lw0, exp_lw1;

   function automatic int aw(int d);
      return (d != 0) ? 4 : 7;
   endfunction

   function automatic int dw(int d);
      return (d != 0) ? 16 : 8;
   endfunction

   function automatic logic [15:0] model_rd(int d, int a);
      if (d != 0) return m1[a % 16];
      return {8'h00, m0[a % 128]};
   endfunction

   task automatic model_write(int d, int a, int n, bit fault);
      for (int i = 0; i < n; i++) begin
         if (!fault) begin
            if (d != 0) m1[(a + i) % 16] = tx[i];
            else        m0[(a + i) % 128] = tx[i][7:0];
         end
      end
      if (d != 0) exp_lw1 = tx[n-1];
      else        exp_lw0 = tx[n-1];
   endtask

   task automatic half();
      repeat (H) @(negedge clk);
   endtask

   task automatic set_cs(int d, logic v);
      if (d != 0) cs1 = v;
      else        cs0 = v;
   endtask

   // One bit time: drive b, return what MISO held at the master's sample edge.
   task automatic spi_bit(input int d, input logic b, output logic got);
      if (d == 0) begin
         mosi0 = b; half();
         sclk0 = 1'b1; got = miso0; half();
         sclk0 = 1'b0;
      end else begin
         sclk1 = 1'b0; mosi1 = b; half();
         got = miso1; sclk1 = 1'b1; half();
      end
   endtask

   // Full frame; cut >= 0 stops after that many data bits.
   task automatic spi_frame(input int d, input logic [15:0] a, input bit rd,
                            input int n, input int cut);
      logic got;
      logic [15:0] w;
      int total, wi, bi;
      w = '0;
      rx.delete();
      set_cs(d, 1'b0); half();
      for (int i = aw(d) - 1; i >= 0; i--) spi_bit(d, a[i], got);
      spi_bit(d, rd, got);
      mid_state = (d != 0) ? st1 : st0;
      mid_oe    = (d != 0) ? oe1 : oe0;
      total = (cut >= 0) ? cut : n * dw(d);
      for (int k = 0; k < total; k++) begin
         wi = k / dw(d);
         bi = dw(d) - 1 - (k % dw(d));
         spi_bit(d, rd ? 1'b0 : tx[wi][bi], got);
         w[bi] = got;
         if (bi == 0) rx.push_back(w);
      end
      half(); set_cs(d, 1'b1);
      repeat (4) @(negedge clk);
      end_state = (d != 0) ? st1 : st0;
      end_oe    = (d != 0) ? oe1 : oe0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      sclk0 = 1'b0; cs0 = 1'b1; mosi0 = 1'b0; fault0 = 1'b0;
      sclk1 = 1'b1; cs1 = 1'b1; mosi1 = 1'b0; fault1 = 1'b0;
      exp_lw0 = '0; exp_lw1 = '0;
      repeat (3) @(negedge clk);
      checks++; if (st0 !== 4'd0) begin errors++; $display("FAIL rst_state0: got %0d expected 0", st0); end
      checks++; if (oe0 !== 1'b0) begin errors++; $display("FAIL rst_oe0: got %b expected 0", oe0); end
      checks++; if (miso0 !== 1'b0) begin errors++; $display("FAIL rst_miso0: got %b expected 0", miso0); end
      checks++; if (lw0 !== 8'h00) begin errors++; $display("FAIL rst_lw0: got %h expected 00", lw0); end
      checks++; if (lw1 !== 16'h0000) begin errors++; $display("FAIL rst_lw1: got %h expected 0000", lw1); end
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      // Idle SCLK high on the mode-3 build must not wake it up.
      checks++; if (st1 !== 4'd0) begin errors++; $display("FAIL idle_state1: got %0d expected 0", st1); end
      checks++; if (oe1 !== 1'b0) begin errors++; $display("FAIL idle_oe1: got %b expected 0", oe1); end
   endtask

   task automatic test_single();
      tx = {16'h00A5};
      spi_frame(0, 16'h12, 1'b0, 1, -1);
      model_write(0, 'h12, 1, 1'b0);
      checks++; if (mid_state !== 4'd3) begin errors++; $display("FAIL t1_wr_state: got %0d expected 3", mid_state); end
      checks++; if (mid_oe !== 1'b1) begin errors++; $display("FAIL t1_wr_oe: got %b expected 1", mid_oe); end
      checks++; if (lw0 !== 8'hA5) begin errors++; $display("FAIL t1_wr_lw: got %h expected a5", lw0); end
      spi_frame(0, 16'h12, 1'b1, 1, -1);
      checks++; if (mid_state !== 4'd2) begin errors++; $display("FAIL t1_rd_state: got %0d expected 2", mid_state); end
      checks++; if (rx.size() != 1 || rx[0] !== 16'h00A5) begin errors++; $display("FAIL t1_rd_data: got %h expected 00a5", (rx.size() > 0) ? rx[0] : 16'hxxxx); end
      checks++; if (lw0 !== 8'hA5) begin errors++; $display("FAIL t1_rd_lw: got %h expected a5", lw0); end
      checks++; if (end_state !== 4'd0) begin errors++; $display("FAIL t1_end_state: got %0d expected 0", end_state); end
      checks++; if (end_oe !== 1'b0) begin errors++; $display("FAIL t1_end_oe: got %b expected 0", end_oe); end
   endtask

   task automatic test_burst_wrap();
      logic [15:0] exp3 [3];
      exp3 = '{16'h0011, 16'h0022, 16'h0033};
      tx = {16'h0011, 16'h0022, 16'h0033};
      spi_frame(0, 16'h7F, 1'b0, 3, -1);
      model_write(0, 'h7F, 3, 1'b0);
      spi_frame(0, 16'h7F, 1'b1, 3, -1);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rx.size() != 3 || rx[i] !== exp3[i]) begin
            errors++; $display("FAIL t2_burst_rd[%0d]: got %h expected %h", i, (i < rx.size()) ? rx[i] : 16'hxxxx, exp3[i]);
         end
      end
      checks++; if (lw0 !== 8'h33) begin errors++; $display("FAIL t2_lw: got %h expected 33", lw0); end
      spi_frame(0, 16'h00, 1'b1, 2, -1);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (rx.size() != 2 || rx[i] !== exp3[i+1]) begin
            errors++; $display("FAIL t2_wrap_rd[%0d]: got %h expected %h", i, (i < rx.size()) ? rx[i] : 16'hxxxx, exp3[i+1]);
         end
      end
   endtask

   task automatic test_partial();
      logic [15:0] v;
      v = 16'($urandom_range(0, 255));
      tx = {v};
      spi_frame(0, 16'h05, 1'b0, 1, -1);
      model_write(0, 'h05, 1, 1'b0);
      tx = {16'($urandom_range(0, 255)) ^ 16'h00FF};
      spi_frame(0, 16'h05, 1'b0, 1, 5);
      checks++; if (end_state !== 4'd0) begin errors++; $display("FAIL t3_state: got %0d expected 0", end_state); end
      checks++; if (end_oe !== 1'b0) begin errors++; $display("FAIL t3_oe: got %b expected 0", end_oe); end
      checks++; if (lw0 !== exp_lw0[7:0]) begin errors++; $display("FAIL t3_lw: got %h expected %h", lw0, exp_lw0[7:0]); end
      spi_frame(0, 16'h05, 1'b1, 1, -1);
      checks++; if (rx.size() != 1 || rx[0] !== model_rd(0, 'h05)) begin errors++; $display("FAIL t3_readback: got %h expected %h", (rx.size() > 0) ? rx[0] : 16'hxxxx, model_rd(0, 'h05)); end
   endtask

   task automatic test_fault();
      tx = {16'h003C};
      spi_frame(0, 16'h20, 1'b0, 1, -1);
      model_write(0, 'h20, 1, 1'b0);
      fault0 = 1'b1;
      tx = {16'h00FF};
      spi_frame(0, 16'h20, 1'b0, 1, -1);
      model_write(0, 'h20, 1, 1'b1);
      fault0 = 1'b0;
      checks++; if (lw0 !== 8'hFF) begin errors++; $display("FAIL t4_lw_fault: got %h expected ff", lw0); end
      spi_frame(0, 16'h20, 1'b1, 1, -1);
      checks++; if (rx.size() != 1 || rx[0] !== 16'h003C) begin errors++; $display("FAIL t4_readback: got %h expected 003c", (rx.size() > 0) ? rx[0] : 16'hxxxx); end
   endtask

   task automatic test_reset_mid_read();
      logic got;
      logic [15:0] a;
      a = 16'h12;
      cs0 = 1'b0; half();
      for (int i = 6; i >= 0; i--) spi_bit(0, a[i], got);
      spi_bit(0, 1'b1, got);
      for (int i = 0; i < 3; i++) spi_bit(0, 1'b0, got);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (st0 !== 4'd0) begin errors++; $display("FAIL t5_state_now: got %0d expected 0", st0); end
      checks++; if (oe0 !== 1'b0) begin errors++; $display("FAIL t5_oe_now: got %b expected 0", oe0); end
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      exp_lw0 = '0; exp_lw1 = '0;
      for (int i = 0; i < 10; i++) spi_bit(0, 1'(i & 1), got);
      checks++; if (st0 !== 4'd0) begin errors++; $display("FAIL t5_ignored_state: got %0d expected 0", st0); end
      checks++; if (oe0 !== 1'b0) begin errors++; $display("FAIL t5_ignored_oe: got %b expected 0", oe0); end
      checks++; if (lw0 !== 8'h00) begin errors++; $display("FAIL t5_lw_cleared: got %h expected 00", lw0); end
      half(); cs0 = 1'b1;
      repeat (8) @(negedge clk);
      spi_frame(0, 16'h12, 1'b1, 1, -1);
      checks++; if (rx.size() != 1 || rx[0] !== model_rd(0, 'h12)) begin errors++; $display("FAIL t5_after_read: got %h expected %h", (rx.size() > 0) ? rx[0] : 16'hxxxx, model_rd(0, 'h12)); end
   endtask

   task automatic test_mode3_wide();
      tx = {16'hBEEF};
      spi_frame(1, 16'h0F, 1'b0, 1, -1);
      model_write(1, 'hF, 1, 1'b0);
      checks++; if (mid_state !== 4'd3) begin errors++; $display("FAIL t6_wr_state: got %0d expected 3", mid_state); end
      checks++; if (lw1 !== 16'hBEEF) begin errors++; $display("FAIL t6_wr_lw: got %h expected beef", lw1); end
      spi_frame(1, 16'h0F, 1'b1, 1, -1);
      checks++; if (mid_state !== 4'd2) begin errors++; $display("FAIL t6_rd_state: got %0d expected 2", mid_state); end
      checks++; if (rx.size() != 1 || rx[0] !== 16'hBEEF) begin errors++; $display("FAIL t6_rd_data: got %h expected beef", (rx.size() > 0) ? rx[0] : 16'hxxxx); end
      checks++; if (end_state !== 4'd0) begin errors++; $display("FAIL t6_end_state: got %0d expected 0", end_state); end
   endtask

   // Random bursts on both builds, checked against the array model.
   task automatic test_random_bursts();
      int d, a, n;
      logic [15:0] e;
      for (int it = 0; it < 9; it++) begin
         d = (it < 6) ? 0 : 1;
         a = (d != 0) ? $urandom_range(0, 15) : $urandom_range(0, 127);
         n = $urandom_range(1, 4);
         tx.delete();
         for (int i = 0; i < n; i++) tx.push_back((d != 0) ? 16'($urandom) : 16'($urandom_range(0, 255)));
         spi_frame(d, 16'(a), 1'b0, n, -1);
         model_write(d, a, n, 1'b0);
         e = (d != 0) ? lw1 : {8'h00, lw0};
         checks++; if (e !== ((d != 0) ? exp_lw1 : {8'h00, exp_lw0[7:0]})) begin errors++; $display("FAIL rnd_wr_lw[%0d]: got %h expected %h", it, e, (d != 0) ? exp_lw1 : exp_lw0); end
         spi_frame(d, 16'(a), 1'b1, n, -1);
         for (int i = 0; i < n; i++) begin
            checks++;
            if (rx.size() != n || rx[i] !== model_rd(d, a + i)) begin
               errors++; $display("FAIL rnd_rd[%0d.%0d]: got %h expected %h", it, i, (i < rx.size()) ? rx[i] : 16'hxxxx, model_rd(d, a + i));
            end
         end
         e = (d != 0) ? lw1 : {8'h00, lw0};
         checks++; if (e !== model_rd(d, a + n - 1)) begin errors++; $display("FAIL rnd_rd_lw[%0d]: got %h expected %h", it, e, model_rd(d, a + n - 1)); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst_wrap();
      test_partial();
      test_fault();
      test_mode3_wide();
      test_random_bursts();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20ms;
      $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
